// File: rtl/neopixel_pkg.sv
// Shared types and default timing for the WS2812-style frame streamer.
package neopixel_pkg;

  localparam int PIX_W      = 24;
  localparam int ADDR_W     = 8;
  localparam int T0H_DEF    = 20;
  localparam int T1H_DEF    = 40;
  localparam int TBIT_DEF   = 63;
  localparam int TRESET_DEF = 15000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    BIT   = 2'd2,
    LATCH = 2'd3
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/neopixel_bit_encoder.sv
// Shared cycle counter: pulse-width encodes one bit while in BIT and times the
// latch period while in LATCH. o_dout is registered and trails the counter by one cycle.
module neopixel_bit_encoder
  import neopixel_pkg::*;
#(
  parameter int T0H    = T0H_DEF,
  parameter int T1H    = T1H_DEF,
  parameter int TBIT   = TBIT_DEF,
  parameter int TRESET = TRESET_DEF,
  parameter int CYC_W  = 14
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_bit_en,
  input  logic i_latch_en,
  input  logic i_bit,
  output logic o_dout,
  output logic o_bit_end,
  output logic o_latch_end
);

  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [CYC_W-1:0] high_len;
  logic             dout_q, dout_d;

  always_comb begin
    high_len    = i_bit ? CYC_W'(T1H) : CYC_W'(T0H);
    o_bit_end   = i_bit_en && (cyc_q == CYC_W'(TBIT - 1));
    // One extra latch cycle compensates for the registered output lag.
    o_latch_end = i_latch_en && (cyc_q == CYC_W'(TRESET));
    cyc_d       = cyc_q + CYC_W'(1);
    if (!(i_bit_en || i_latch_en) || o_bit_end || o_latch_end) begin
      cyc_d = '0;
    end
    dout_d = i_bit_en && (cyc_q < high_len);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cyc_q  <= '0;
      dout_q <= 1'b0;
    end else begin
      cyc_q  <= cyc_d;
      dout_q <= dout_d;
    end
  end

  assign o_dout = dout_q;

endmodule

// File: rtl/neopixel_ctrl.sv
// Frame controller: walks pixel memory 0..last through the async read port and
// streams each 24-bit word MSB first, then holds the line low for the latch period.
module neopixel_ctrl
  import neopixel_pkg::*;
#(
  parameter int T0H    = T0H_DEF,
  parameter int T1H    = T1H_DEF,
  parameter int TBIT   = TBIT_DEF,
  parameter int TRESET = TRESET_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_last_addr,
  output logic [ADDR_W-1:0] o_rs_addr,
  input  logic [PIX_W-1:0]  i_rs_data,
  output logic              o_dout,
  output logic              o_busy,
  output logic              o_done
);

  // Wide enough to hold TRESET itself (latch counter's final value).
  localparam int CYC_W = $clog2(max_int(TBIT, TRESET) + 1);

  state_t            state_q, state_d;
  logic [PIX_W-1:0]  shreg_q, shreg_d;
  logic [4:0]        bitcnt_q, bitcnt_d;
  logic [ADDR_W-1:0] pix_q, pix_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic [ADDR_W-1:0] rs_addr_q, rs_addr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              bit_end, latch_end;

  neopixel_bit_encoder #(
    .T0H   (T0H),
    .T1H   (T1H),
    .TBIT  (TBIT),
    .TRESET(TRESET),
    .CYC_W (CYC_W)
  ) u_enc (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_bit_en   (state_q == BIT),
    .i_latch_en (state_q == LATCH),
    .i_bit      (shreg_q[PIX_W-1]),
    .o_dout     (o_dout),
    .o_bit_end  (bit_end),
    .o_latch_end(latch_end)
  );

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bitcnt_d  = bitcnt_q;
    pix_d     = pix_q;
    last_d    = last_q;
    rs_addr_d = rs_addr_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (i_start) begin
          last_d    = i_last_addr;
          pix_d     = '0;
          rs_addr_d = '0;
          busy_d    = 1'b1;
          state_d   = LOAD;
        end
      end
      LOAD: begin
        shreg_d   = i_rs_data;
        bitcnt_d  = 5'(PIX_W - 1);
        rs_addr_d = rs_addr_q + ADDR_W'(1);
        state_d   = BIT;
      end
      BIT: begin
        if (bit_end) begin
          if (bitcnt_q != 5'd0) begin
            shreg_d  = {shreg_q[PIX_W-2:0], 1'b0};
            bitcnt_d = bitcnt_q - 5'd1;
          end else if (pix_q != last_q) begin
            // Next word is already on the read port; load it with no gap.
            shreg_d   = i_rs_data;
            pix_d     = pix_q + ADDR_W'(1);
            rs_addr_d = rs_addr_q + ADDR_W'(1);
            bitcnt_d  = 5'(PIX_W - 1);
          end else begin
            state_d = LATCH;
          end
        end
      end
      LATCH: begin
        if (latch_end) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bitcnt_q  <= '0;
      pix_q     <= '0;
      last_q    <= '0;
      rs_addr_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bitcnt_q  <= bitcnt_d;
      pix_q     <= pix_d;
      last_q    <= last_d;
      rs_addr_q <= rs_addr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign o_rs_addr = rs_addr_q;
  assign o_busy    = busy_q;
  assign o_done    = done_q;

endmodule

// File: tb/tb_neopixel_ctrl.sv
// Directed bench for neopixel_ctrl with short timing (T0H=2, T1H=4, TBIT=6, TRESET=10).
module tb_neopixel_ctrl;

  localparam int T0H    = 2;
  localparam int T1H    = 4;
  localparam int TBIT   = 6;
  localparam int TRESET = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  last_addr;
  logic [7:0]  rs_addr;
  logic [23:0] rs_data;
  logic        dout, busy, done;
  logic [23:0] mem [256];

  assign rs_data = mem[rs_addr];
  always #5 clk = ~clk;

  neopixel_ctrl #(
    .T0H(T0H), .T1H(T1H), .TBIT(TBIT), .TRESET(TRESET)
  ) u_dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start),
    .i_last_addr(last_addr),
    .o_rs_addr  (rs_addr),
    .i_rs_data  (rs_data),
    .o_dout     (dout),
    .o_busy     (busy),
    .o_done     (done)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end else begin
      $display("ok   %s = %0d", name, act);
    end
  endtask

  // Results of the most recent frame
  int         f_len, f_bits, f_high, f_wave_err, f_busy_err;
  logic [7:0] f_addr0, f_addr1, f_addr_p1, f_addr_end;

  // Requests a frame at the current negedge and follows it sample-by-sample
  // (sample k is taken at the negedge after the k-th edge past the accept edge).
  task automatic run_frame(input int last, input bit hold, input int mid_k, input logic [7:0] mid_last);
    int          n;
    int          bound;
    int          t;
    logic        exp_pin;
    logic        prev;
    logic [23:0] w;
    n          = last + 1;
    bound      = 2 + 24 * TBIT * n + TRESET + 40;
    last_addr  = 8'(last);
    start      = 1'b1;
    f_len      = -1;
    f_bits     = 0;
    f_high     = 0;
    f_wave_err = 0;
    f_busy_err = 0;
    prev       = 1'b0;
    @(posedge clk);
    for (int k = 0; k < bound; k++) begin
      @(negedge clk);
      if (k == 0 && !hold) start = 1'b0;
      if (k == mid_k) last_addr = mid_last;
      if (k == 0) f_addr0 = rs_addr;
      if (k == 1) f_addr1 = rs_addr;
      if (k == 1 + 24 * TBIT) f_addr_p1 = rs_addr;
      exp_pin = 1'b0;
      if (k >= 2 && k < 2 + 24 * TBIT * n) begin
        t = k - 2;
        w = mem[t / (24 * TBIT)];
        exp_pin = ((t % TBIT) < (w[23 - (t % (24 * TBIT)) / TBIT] ? T1H : T0H));
      end
      if (dout !== exp_pin) f_wave_err++;
      if (dout === 1'b1) f_high++;
      if (dout === 1'b1 && prev === 1'b0) f_bits++;
      prev = dout;
      if (done === 1'b1) begin
        f_len      = k;
        f_addr_end = rs_addr;
        if (busy !== 1'b0) f_busy_err++;
        break;
      end else if (busy !== 1'b1) begin
        f_busy_err++;
      end
    end
  endtask

  typedef struct {
    int          last;
    logic [23:0] d0;
    logic [23:0] d1;
    int          exp_len;
    int          exp_bits;
    int          exp_high;
  } vec_t;

  vec_t vecs [4];
  int   idle_busy, idle_done, idle_dout;

  initial begin
    vecs[0] = '{0, 24'hA50000, 24'h000000, 156, 24, 56};
    vecs[1] = '{1, 24'hFFFFFF, 24'h000000, 300, 48, 144};
    vecs[2] = '{0, 24'h800001, 24'h000000, 156, 24, 52};
    vecs[3] = '{1, 24'h000001, 24'h800000, 300, 48, 100};
    for (int i = 0; i < 256; i++) mem[i] = 24'h0;

    // Async reset before any clock edge
    rst = 1'b0; start = 1'b0; last_addr = 8'd0;
    #2 rst = 1'b1;
    #1;
    chk("rst_dout", {31'd0, dout}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_addr", {24'd0, rs_addr}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle_busy = 0; idle_done = 0; idle_dout = 0;
    repeat (5) begin
      @(negedge clk);
      idle_busy += (busy !== 1'b0);
      idle_done += (done !== 1'b0);
      idle_dout += (dout !== 1'b0);
    end
    chk("idle_hold_busy_err", idle_busy, 0);
    chk("idle_hold_done_err", idle_done, 0);
    chk("idle_hold_dout_err", idle_dout, 0);

    // Table-driven frames
    for (int v = 0; v < 4; v++) begin
      mem[0] = vecs[v].d0;
      mem[1] = vecs[v].d1;
      run_frame(vecs[v].last, 1'b0, -1, 8'd0);
      $display("frame v%0d last=%0d d0=%06h d1=%06h len=%0d bits=%0d high=%0d",
               v, vecs[v].last, vecs[v].d0, vecs[v].d1, f_len, f_bits, f_high);
      chk($sformatf("v%0d_len", v), f_len, vecs[v].exp_len);
      chk($sformatf("v%0d_bits", v), f_bits, vecs[v].exp_bits);
      chk($sformatf("v%0d_high", v), f_high, vecs[v].exp_high);
      chk($sformatf("v%0d_wave_err", v), f_wave_err, 0);
      chk($sformatf("v%0d_busy_err", v), f_busy_err, 0);
      chk($sformatf("v%0d_addr0", v), {24'd0, f_addr0}, 0);
      chk($sformatf("v%0d_addr1", v), {24'd0, f_addr1}, 1);
      if (vecs[v].last == 1) chk($sformatf("v%0d_addr_p1", v), {24'd0, f_addr_p1}, 2);
      @(negedge clk);
      chk($sformatf("v%0d_done_width", v), {31'd0, done}, 0);
      repeat (3) @(negedge clk);
    end

    // Held start: one frame per IDLE entry, re-accepted in the done cycle;
    // a mid-frame change of i_last_addr must not lengthen the frame.
    mem[0] = 24'hA50000;
    mem[1] = 24'h000000;
    run_frame(0, 1'b1, 50, 8'd3);
    chk("hold1_len", f_len, 156);
    chk("hold1_wave_err", f_wave_err, 0);
    chk("hold1_busy_err", f_busy_err, 0);
    run_frame(0, 1'b0, -1, 8'd0);
    chk("hold2_len", f_len, 156);
    chk("hold2_wave_err", f_wave_err, 0);
    chk("hold2_busy_err", f_busy_err, 0);
    repeat (3) @(negedge clk);

    // Reset during bit 5 of pixel 0
    last_addr = 8'd0;
    start     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (32) @(negedge clk);
    chk("pre_rst_dout", {31'd0, dout}, 1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_dout", {31'd0, dout}, 0);
    chk("midrst_busy", {31'd0, busy}, 0);
    chk("midrst_addr", {24'd0, rs_addr}, 0);
    #1 rst = 1'b0;
    idle_busy = 0; idle_done = 0;
    repeat (200) begin
      @(negedge clk);
      idle_busy += (busy !== 1'b0);
      idle_done += (done !== 1'b0);
    end
    chk("postrst_no_done", idle_done, 0);
    chk("postrst_no_busy", idle_busy, 0);
    run_frame(0, 1'b0, -1, 8'd0);
    chk("postrst_len", f_len, 156);
    chk("postrst_wave_err", f_wave_err, 0);
    repeat (3) @(negedge clk);

    // Full 256-pixel frame, mem[k]=k; address wraps to 0 after last load
    for (int i = 0; i < 256; i++) mem[i] = 24'(i);
    run_frame(255, 1'b0, -1, 8'd0);
    chk("full_len", f_len, 36876);
    chk("full_bits", f_bits, 6144);
    chk("full_high", f_high, 14336);
    chk("full_wave_err", f_wave_err, 0);
    chk("full_busy_err", f_busy_err, 0);
    chk("full_addr_wrap", {24'd0, f_addr_end}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
